cc_data_reorder_unit_p: RTL and testbench
=========================================

# cc_data_reorder_unit_p

Parametrised read-return reorder unit for the cache controller (CC). It merges cache-hit line data from the hit pipeline with miss data from the memory AXI R channel, and drives one in-order R stream toward the interconnect (INCT), using a per-request hit/miss flag FIFO. It adds three things over the fixed 64-bit/8-beat version: generic data width, burst length and FIFO depths; critical-word-first wrap ordering of hit lines; and a sticky rlast-mismatch error on miss bursts.

## Interface
- DATA_W, 64, beat width in bits (power of 2, ≥ 8)
- BEATS, 8, beats per cache line (power of 2, ≥ 2)
- FLAG_DEPTH, 4, hit-flag FIFO depth
- FLAG_AFULL, 2, flag FIFO almost-full threshold
- HDATA_DEPTH, 2, hit-data FIFO depth
- HDATA_AFULL, 1, hit-data FIFO almost-full threshold
- Derived: OFF_W = $clog2(DATA_W/8*BEATS) (byte offset in line); HD_W = DATA_W*BEATS + OFF_W; BIDX_W = $clog2(BEATS)

Reset rst_n, synchronous, active-low; clock clk.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- mem_rdata_i  in  DATA_W  memory R data
- mem_rlast_i  in  1  memory R last
- mem_rvalid_i  in  1  memory R valid
- mem_rready_o  out  1  memory R ready
- hit_flag_fifo_afull_o  out  1  flag FIFO almost full
- hit_flag_fifo_wren_i  in  1  flag push
- hit_flag_fifo_wdata_i  in  1  1 = hit, 0 = miss
- hit_data_fifo_afull_o  out  1  hit-data FIFO almost full
- hit_data_fifo_wren_i  in  1  hit-data push
- hit_data_fifo_wdata_i  in  HD_W  {byte_offset[OFF_W-1:0], line[DATA_W*BEATS-1:0]}; beat k = line[k*DATA_W +: DATA_W]
- inct_rdata_o  out  DATA_W  INCT R data
- inct_rlast_o  out  1  INCT R last
- inct_rvalid_o  out  1  INCT R valid
- inct_rready_i  in  1  INCT R ready
- err_o  out  1  sticky: mem_rlast_i disagreed with local beat count

## Operation
- FSM states: IDLE, MISS, HIT. Beat counter cnt[BIDX_W-1:0].
- IDLE: if the flag FIFO is not empty, pop it. Next state is MISS (flag 0) or HIT (flag 1), with cnt = 0. Otherwise stay in IDLE.
- MISS is a combinational pass-through:
  - inct_rvalid_o = mem_rvalid_i; mem_rready_o = inct_rready_i; inct_rdata_o = mem_rdata_i.
  - inct_rlast_o = (cnt == BEATS-1) is generated locally; mem_rlast_i is not forwarded.
  - On a handshake, cnt++. If mem_rlast_i != (cnt == BEATS-1) on that beat, err_o is set to 1 and held until reset.
- HIT has an internal line_valid flag:
  - If !line_valid and the hit-data FIFO is not empty: pop it, load the line register, set start = offset[OFF_W-1:OFF_W-BIDX_W] (the beat index), set line_valid = 1.
  - While line_valid: inct_rvalid_o = 1 and inct_rdata_o = line[(start+cnt) mod BEATS]. The wrap is the natural BIDX_W-bit overflow.
  - inct_rlast_o = (cnt == BEATS-1). mem_rready_o = 0.
- Burst end: on the handshake of the last beat, clear line_valid. If the flag FIFO is not empty, pop the next flag in the same cycle and go directly to MISS or HIT with cnt = 0 (no bubble). Otherwise go to IDLE.
- In IDLE and HIT, mem_rready_o = 0. In IDLE and while HIT has no line, inct_rvalid_o = 0.
- Outputs hold stable while valid && !ready, per the AXI rule.
- Pushes to a full FIFO are a protocol violation by the upstream. The afull outputs must be honoured; behaviour on overflow is undefined.
- A flag can lead its hit data; HIT waits for the data with no timeout.

## Timing
- Reset values: mem_rready_o 0, inct_rvalid_o 0, inct_rlast_o 0, inct_rdata_o 0, err_o 0, afull outputs 0; FSM in IDLE; both FIFOs empty.
- Reset mid-burst: the burst is abandoned and FIFO contents are discarded. No output valid in the cycle after reset is deasserted.
- Latency, flag push to pop: 1 cycle (FIFO registered). Pop in IDLE at cycle N gives the state active at N+1.
- MISS adds 0 cycles of latency (combinational path).
- HIT: hit-data pop at cycle N gives the first beat valid at N+1. Back-to-back hit lines have a 1-cycle bubble unless the next line is prefetched (optional, not required).
- Simultaneous push and pop on either FIFO is legal, including when the FIFO is full with a pop.

## Structure
- Package cc_reorder_pkg: state enum (IDLE, MISS, HIT) and the default parameter constants.
- Reuse the existing CC_FIFO for the flag and hit-data FIFOs.
- One sub-module, cc_line_serializer_wrap: line register, line_valid, start index and wrapped beat select. It takes fifo_empty, fifo_rdata, fifo_rden, rdata/rvalid/rready and cnt_last.

## Test plan
- Single miss: flag 0, mem sends 8 beats 0x10..0x17 with rlast on beat 7 and ready always 1 → INCT sees 0x10..0x17 with zero latency, rlast on beat 7, err_o 0.
- Single hit, offset 0x18: line beats k = 0xA0+k → INCT order A3,A4,A5,A6,A7,A0,A1,A2, rlast on A2, mem_rready_o stays 0.
- Interleaved flags 0,1,0 with the hit data pushed before the mem data arrives → output order is miss burst, hit burst, miss burst. The hit data is not reordered ahead of the first miss, and there is no bubble between the two miss-to-hit boundaries once data is present.
- Backpressure: inct_rready_i toggles 1,0,0,1 during a hit burst → data is held during stalls and all 8 beats are delivered exactly once.
- rlast error: memory asserts rlast on beat 5 → err_o rises on that handshake and stays 1; INCT rlast is still on local beat 7.
- Reset mid-hit after 3 beats → all outputs go to 0, the FIFOs are empty, and a fresh miss afterwards completes normally. Also cover parameter set DATA_W=32, BEATS=16: offset 0x3C gives start beat 15.

Source files
------------

// File: rtl/cc_reorder_pkg.sv
// Shared types and default parameters for the CC read-return reorder unit.
package cc_reorder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    HIT  = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_W      = 64;
  localparam int unsigned DEF_BEATS       = 8;
  localparam int unsigned DEF_FLAG_DEPTH  = 4;
  localparam int unsigned DEF_FLAG_AFULL  = 2;
  localparam int unsigned DEF_HDATA_DEPTH = 2;
  localparam int unsigned DEF_HDATA_AFULL = 1;

endpackage

// File: rtl/cc_data_reorder_unit_p_serializer.sv
// Hit-line serializer: holds one cache line and emits its beats in
// critical-word-first wrap order starting from the requested beat.
module cc_line_serializer_wrap #(
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned BEATS  = 8,
  localparam int unsigned LINE_W = DATA_W * BEATS,
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8 * BEATS),
  localparam int unsigned HD_W   = LINE_W + OFF_W,
  localparam int unsigned BIDX_W = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en_i,
  input  logic              fifo_empty_i,
  input  logic [HD_W-1:0]   fifo_rdata_i,
  output logic              fifo_rden_o,
  input  logic              cnt_last_i,
  input  logic              rready_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [LINE_W-1:0] line_q, line_d;
  logic [BIDX_W-1:0] idx_q, idx_d;
  logic              line_valid_q, line_valid_d;
  logic              hs, done;

  assign hs   = line_valid_q && rready_i;
  assign done = hs && cnt_last_i;

  // Loading is allowed while the FSM is (about to be) in HIT; a line can be
  // taken in the same cycle the previous burst or miss finishes, avoiding a bubble.
  assign fifo_rden_o = load_en_i && !fifo_empty_i && (!line_valid_q || done);

  // Line load, beat index advance (natural BIDX_W-bit wrap) and line release.
  always_comb begin
    line_d       = line_q;
    idx_d        = idx_q;
    line_valid_d = line_valid_q;
    if (fifo_rden_o) begin
      line_d       = fifo_rdata_i[LINE_W-1:0];
      idx_d        = fifo_rdata_i[HD_W-1 -: BIDX_W];
      line_valid_d = 1'b1;
    end else if (done) begin
      line_valid_d = 1'b0;
    end else if (hs) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Line holding registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_q       <= '0;
      idx_q        <= '0;
      line_valid_q <= 1'b0;
    end else begin
      line_q       <= line_d;
      idx_q        <= idx_d;
      line_valid_q <= line_valid_d;
    end
  end

  assign rvalid_o = line_valid_q;
  assign rdata_o  = line_valid_q ? line_q[idx_q*DATA_W +: DATA_W] : '0;

  // Byte-within-beat offset bits do not affect beat ordering.
  if (OFF_W > BIDX_W) begin : g_sub_beat
    logic unused_sub_beat_off;
    assign unused_sub_beat_off = ^fifo_rdata_i[HD_W-BIDX_W-1:LINE_W];
  end

endmodule

// File: rtl/cc_fifo.sv
// Show-ahead synchronous FIFO used for the hit-flag and hit-data queues.
// afull_o is asserted when the occupancy reaches AFULL entries.
module CC_FIFO #(
  parameter  int unsigned WIDTH = 1,
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned AFULL = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wren_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rden_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             afull_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is accepted only when a pop frees a slot that cycle.
  assign do_pop  = rden_i && (cnt_q != '0);
  assign do_push = wren_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

  // Next-state pointers and occupancy.
  always_comb begin
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers, flushed by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign afull_o = (cnt_q >= CNT_W'(AFULL));

endmodule

// File: rtl/cc_data_reorder_unit_p.sv
// Read-return reorder unit: merges hit lines and memory miss bursts into a
// single in-order INCT R stream, steered by a per-request hit/miss flag FIFO.
module cc_data_reorder_unit_p
  import cc_reorder_pkg::*;
#(
  parameter  int unsigned DATA_W      = DEF_DATA_W,
  parameter  int unsigned BEATS       = DEF_BEATS,
  parameter  int unsigned FLAG_DEPTH  = DEF_FLAG_DEPTH,
  parameter  int unsigned FLAG_AFULL  = DEF_FLAG_AFULL,
  parameter  int unsigned HDATA_DEPTH = DEF_HDATA_DEPTH,
  parameter  int unsigned HDATA_AFULL = DEF_HDATA_AFULL,
  localparam int unsigned LINE_W      = DATA_W * BEATS,
  localparam int unsigned OFF_W       = $clog2(DATA_W / 8 * BEATS),
  localparam int unsigned HD_W        = LINE_W + OFF_W,
  localparam int unsigned BIDX_W      = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rlast_i,
  input  logic              mem_rvalid_i,
  output logic              mem_rready_o,
  output logic              hit_flag_fifo_afull_o,
  input  logic              hit_flag_fifo_wren_i,
  input  logic              hit_flag_fifo_wdata_i,
  output logic              hit_data_fifo_afull_o,
  input  logic              hit_data_fifo_wren_i,
  input  logic [HD_W-1:0]   hit_data_fifo_wdata_i,
  output logic [DATA_W-1:0] inct_rdata_o,
  output logic              inct_rlast_o,
  output logic              inct_rvalid_o,
  input  logic              inct_rready_i,
  output logic              err_o
);

  state_e            state_q, state_d;
  logic [BIDX_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              cnt_last, burst_done;

  logic              flag_empty, flag_rdata, flag_rden;
  logic              hd_empty, hd_rden;
  logic [HD_W-1:0]   hd_rdata;
  logic              ser_rvalid;
  logic [DATA_W-1:0] ser_rdata;

  assign cnt_last = (cnt_q == BIDX_W'(BEATS - 1));

  CC_FIFO #(
    .WIDTH(1),
    .DEPTH(FLAG_DEPTH),
    .AFULL(FLAG_AFULL)
  ) u_flag_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wren_i (hit_flag_fifo_wren_i),
    .wdata_i(hit_flag_fifo_wdata_i),
    .rden_i (flag_rden),
    .rdata_o(flag_rdata),
    .empty_o(flag_empty),
    .afull_o(hit_flag_fifo_afull_o)
  );

  CC_FIFO #(
    .WIDTH(HD_W),
    .DEPTH(HDATA_DEPTH),
    .AFULL(HDATA_AFULL)
  ) u_hdata_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wren_i (hit_data_fifo_wren_i),
    .wdata_i(hit_data_fifo_wdata_i),
    .rden_i (hd_rden),
    .rdata_o(hd_rdata),
    .empty_o(hd_empty),
    .afull_o(hit_data_fifo_afull_o)
  );

  cc_line_serializer_wrap #(
    .DATA_W(DATA_W),
    .BEATS (BEATS)
  ) u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_en_i   (state_d == HIT),
    .fifo_empty_i(hd_empty),
    .fifo_rdata_i(hd_rdata),
    .fifo_rden_o (hd_rden),
    .cnt_last_i  (cnt_last),
    .rready_i    (inct_rready_i),
    .rvalid_o    (ser_rvalid),
    .rdata_o     (ser_rdata)
  );

  // Next-state, beat counting, rlast check and R-channel steering.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    flag_rden     = 1'b0;
    burst_done    = 1'b0;
    mem_rready_o  = 1'b0;
    inct_rvalid_o = 1'b0;
    inct_rlast_o  = 1'b0;
    inct_rdata_o  = '0;
    case (state_q)
      IDLE: ;
      MISS: begin
        inct_rvalid_o = mem_rvalid_i;
        mem_rready_o  = inct_rready_i;
        inct_rdata_o  = mem_rdata_i;
        inct_rlast_o  = cnt_last;
        if (mem_rvalid_i && inct_rready_i) begin
          cnt_d      = cnt_q + 1'b1;
          burst_done = cnt_last;
          if (mem_rlast_i != cnt_last) err_d = 1'b1;
        end
      end
      HIT: begin
        inct_rvalid_o = ser_rvalid;
        inct_rdata_o  = ser_rdata;
        inct_rlast_o  = ser_rvalid && cnt_last;
        if (ser_rvalid && inct_rready_i) begin
          cnt_d      = cnt_q + 1'b1;
          burst_done = cnt_last;
        end
      end
      default: state_d = IDLE;
    endcase
    // The next flag is consumed in IDLE or on the last beat, so bursts chain without a gap.
    if ((state_q == IDLE) || burst_done) begin
      if (!flag_empty) begin
        flag_rden = 1'b1;
        state_d   = flag_rdata ? HIT : MISS;
        cnt_d     = '0;
      end else if (burst_done) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  // FSM, beat counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_cc_data_reorder_unit_p.sv
// Directed bench for the reorder unit: default parameters plus a
// DATA_W=32/BEATS=16 instance for the wide wrap case.
module tb_cc_data_reorder_unit_p;

  localparam int unsigned DW  = 64;
  localparam int unsigned BT  = 8;
  localparam int unsigned OW  = 6;
  localparam int unsigned HW  = DW * BT + OW;
  localparam int unsigned DW2 = 32;
  localparam int unsigned BT2 = 16;
  localparam int unsigned OW2 = 6;
  localparam int unsigned HW2 = DW2 * BT2 + OW2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0] mem_rdata;
  logic          mem_rlast, mem_rvalid, mem_rready;
  logic          flag_afull, flag_wren, flag_wdata;
  logic          hd_afull, hd_wren;
  logic [HW-1:0] hd_wdata;
  logic [DW-1:0] rdata;
  logic          rlast, rvalid, rready, err;

  logic [DW2-1:0] b_mem_rdata;
  logic           b_mem_rlast, b_mem_rvalid, b_mem_rready;
  logic           b_flag_afull, b_flag_wren, b_flag_wdata;
  logic           b_hd_afull, b_hd_wren;
  logic [HW2-1:0] b_hd_wdata;
  logic [DW2-1:0] b_rdata;
  logic           b_rlast, b_rvalid, b_rready, b_err;

  int n_asrt = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  cc_data_reorder_unit_p u0 (
    .clk(clk), .rst_n(rst_n),
    .mem_rdata_i(mem_rdata), .mem_rlast_i(mem_rlast), .mem_rvalid_i(mem_rvalid),
    .mem_rready_o(mem_rready),
    .hit_flag_fifo_afull_o(flag_afull), .hit_flag_fifo_wren_i(flag_wren),
    .hit_flag_fifo_wdata_i(flag_wdata),
    .hit_data_fifo_afull_o(hd_afull), .hit_data_fifo_wren_i(hd_wren),
    .hit_data_fifo_wdata_i(hd_wdata),
    .inct_rdata_o(rdata), .inct_rlast_o(rlast), .inct_rvalid_o(rvalid),
    .inct_rready_i(rready), .err_o(err)
  );

  cc_data_reorder_unit_p #(.DATA_W(DW2), .BEATS(BT2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .mem_rdata_i(b_mem_rdata), .mem_rlast_i(b_mem_rlast), .mem_rvalid_i(b_mem_rvalid),
    .mem_rready_o(b_mem_rready),
    .hit_flag_fifo_afull_o(b_flag_afull), .hit_flag_fifo_wren_i(b_flag_wren),
    .hit_flag_fifo_wdata_i(b_flag_wdata),
    .hit_data_fifo_afull_o(b_hd_afull), .hit_data_fifo_wren_i(b_hd_wren),
    .hit_data_fifo_wdata_i(b_hd_wdata),
    .inct_rdata_o(b_rdata), .inct_rlast_o(b_rlast), .inct_rvalid_o(b_rvalid),
    .inct_rready_i(b_rready), .err_o(b_err)
  );

  function automatic logic [HW-1:0] mk_line(input logic [DW-1:0] base, input logic [OW-1:0] off);
    logic [HW-1:0] v;
    v = '0;
    v[HW-1 -: OW] = off;
    for (int k = 0; k < int'(BT); k++) v[k*DW +: DW] = base + DW'(k);
    return v;
  endfunction

  function automatic logic [HW2-1:0] mk_line2(input logic [DW2-1:0] base, input logic [OW2-1:0] off);
    logic [HW2-1:0] v;
    v = '0;
    v[HW2-1 -: OW2] = off;
    for (int k = 0; k < int'(BT2); k++) v[k*DW2 +: DW2] = base + DW2'(k);
    return v;
  endfunction

  logic [DW-1:0] hit_order [8] = '{64'hA3, 64'hA4, 64'hA5, 64'hA6, 64'hA7, 64'hA0, 64'hA1, 64'hA2};
  logic [DW-1:0] rst_order [3] = '{64'hE2, 64'hE3, 64'hE4};
  logic          bp_pat    [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  int            beat;

  initial begin
    rst_n = 1'b0;
    mem_rdata = '0; mem_rlast = 1'b0; mem_rvalid = 1'b0; rready = 1'b0;
    flag_wren = 1'b0; flag_wdata = 1'b0; hd_wren = 1'b0; hd_wdata = '0;
    b_mem_rdata = '0; b_mem_rlast = 1'b0; b_mem_rvalid = 1'b0; b_rready = 1'b0;
    b_flag_wren = 1'b0; b_flag_wdata = 1'b0; b_hd_wren = 1'b0; b_hd_wdata = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_mem_rready", mem_rready, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_flag_afull", flag_afull, 1'b0);
    chk("rst_hd_afull", hd_afull, 1'b0);
    chk("rst_b_rvalid", b_rvalid, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_rvalid", rvalid, 1'b0);

    // Single miss, zero-latency pass-through
    @(negedge clk); flag_wren = 1'b1; flag_wdata = 1'b0;
    @(negedge clk); flag_wren = 1'b0; rready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 64'(16 + k); mem_rlast = (k == 7);
      #1;
      chk($sformatf("miss1_rvalid[%0d]", k), rvalid, 1'b1);
      chk($sformatf("miss1_rdata[%0d]", k), rdata, 64'(16 + k));
      chk($sformatf("miss1_rlast[%0d]", k), rlast, (k == 7));
      chk($sformatf("miss1_mem_rready[%0d]", k), mem_rready, 1'b1);
    end
    @(negedge clk); mem_rvalid = 1'b0; mem_rlast = 1'b0; #1;
    chk("miss1_idle_rvalid", rvalid, 1'b0);
    chk("miss1_err", err, 1'b0);

    // Single hit, offset 0x18 -> start at beat 3; memory valid must be ignored
    @(negedge clk);
    flag_wren = 1'b1; flag_wdata = 1'b1; hd_wren = 1'b1; hd_wdata = mk_line(64'hA0, 6'h18);
    @(negedge clk); flag_wren = 1'b0; hd_wren = 1'b0; #1;
    chk("hit1_hd_afull", hd_afull, 1'b1);
    chk("hit1_flag_afull", flag_afull, 1'b0);
    chk("hit1_wait_rvalid", rvalid, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 64'hDEAD;
      #1;
      chk($sformatf("hit1_rvalid[%0d]", k), rvalid, 1'b1);
      chk($sformatf("hit1_rdata[%0d]", k), rdata, hit_order[k]);
      chk($sformatf("hit1_rlast[%0d]", k), rlast, (k == 7));
      chk($sformatf("hit1_mem_rready[%0d]", k), mem_rready, 1'b0);
    end
    @(negedge clk); mem_rvalid = 1'b0; #1;
    chk("hit1_idle_rvalid", rvalid, 1'b0);
    chk("hit1_hd_afull_after", hd_afull, 1'b0);

    // Interleaved flags 0,1,0 with hit data queued before any memory data
    @(negedge clk);
    flag_wren = 1'b1; flag_wdata = 1'b0; hd_wren = 1'b1; hd_wdata = mk_line(64'hB0, 6'h08);
    @(negedge clk); hd_wren = 1'b0; flag_wdata = 1'b1;
    @(negedge clk); flag_wdata = 1'b0; #1;
    chk("ilv_no_early_hit", rvalid, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      flag_wren = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'(32 + k); mem_rlast = (k == 7);
      #1;
      chk($sformatf("ilv_m1_rvalid[%0d]", k), rvalid, 1'b1);
      chk($sformatf("ilv_m1_rdata[%0d]", k), rdata, 64'(32 + k));
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rlast = 1'b0;
      #1;
      chk($sformatf("ilv_h_rvalid[%0d]", k), rvalid, 1'b1);
      chk($sformatf("ilv_h_rdata[%0d]", k), rdata, 64'(8'hB0 + ((1 + k) % 8)));
      chk($sformatf("ilv_h_rlast[%0d]", k), rlast, (k == 7));
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 64'(48 + k); mem_rlast = (k == 7);
      #1;
      chk($sformatf("ilv_m2_rvalid[%0d]", k), rvalid, 1'b1);
      chk($sformatf("ilv_m2_rdata[%0d]", k), rdata, 64'(48 + k));
      chk($sformatf("ilv_m2_rlast[%0d]", k), rlast, (k == 7));
    end
    @(negedge clk); mem_rvalid = 1'b0; mem_rlast = 1'b0; #1;
    chk("ilv_idle_rvalid", rvalid, 1'b0);

    // Backpressure during a hit burst: ready 1,0,0,1,...
    @(negedge clk);
    flag_wren = 1'b1; flag_wdata = 1'b1; hd_wren = 1'b1; hd_wdata = mk_line(64'hC0, 6'h00);
    @(negedge clk); flag_wren = 1'b0; hd_wren = 1'b0;
    beat = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rready = bp_pat[c];
      #1;
      chk($sformatf("bp_rvalid[%0d]", c), rvalid, 1'b1);
      chk($sformatf("bp_rdata[%0d]", c), rdata, 64'(8'hC0 + beat));
      chk($sformatf("bp_rlast[%0d]", c), rlast, (beat == 7));
      if (bp_pat[c]) beat++;
    end
    @(negedge clk); rready = 1'b1; #1;
    chk("bp_no_extra_beat", rvalid, 1'b0);

    // Memory rlast on beat 5: sticky error, local rlast still on beat 7
    @(negedge clk); flag_wren = 1'b1; flag_wdata = 1'b0;
    @(negedge clk); flag_wren = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 64'(80 + k); mem_rlast = (k == 5);
      #1;
      chk($sformatf("rle_err[%0d]", k), err, (k > 5));
      chk($sformatf("rle_rlast[%0d]", k), rlast, (k == 7));
      chk($sformatf("rle_rdata[%0d]", k), rdata, 64'(80 + k));
    end
    @(negedge clk); mem_rvalid = 1'b0; mem_rlast = 1'b0; #1;
    chk("rle_err_sticky", err, 1'b1);

    // Reset mid-hit after 3 beats, with a flag and a line still queued
    @(negedge clk);
    flag_wren = 1'b1; flag_wdata = 1'b1; hd_wren = 1'b1; hd_wdata = mk_line(64'hE0, 6'h10);
    @(negedge clk); flag_wdata = 1'b0; hd_wdata = mk_line(64'hF0, 6'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      flag_wren = 1'b0; hd_wren = 1'b0;
      #1;
      chk($sformatf("rsth_rdata[%0d]", k), rdata, rst_order[k]);
    end
    chk("rsth_err_before", err, 1'b1);
    chk("rsth_hd_afull_before", hd_afull, 1'b1);
    @(negedge clk); rst_n = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h55;
    @(negedge clk); #1;
    chk("rsth_rvalid", rvalid, 1'b0);
    chk("rsth_rlast", rlast, 1'b0);
    chk("rsth_rdata", rdata, 64'h0);
    chk("rsth_mem_rready", mem_rready, 1'b0);
    chk("rsth_err", err, 1'b0);
    chk("rsth_flag_afull", flag_afull, 1'b0);
    chk("rsth_hd_afull", hd_afull, 1'b0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rsth_release_rvalid", rvalid, 1'b0);
    @(negedge clk); #1;
    chk("rsth_flushed_rvalid", rvalid, 1'b0);
    chk("rsth_flushed_mem_rready", mem_rready, 1'b0);
    mem_rvalid = 1'b0;

    // Fresh miss after reset
    @(negedge clk); flag_wren = 1'b1; flag_wdata = 1'b0;
    @(negedge clk); flag_wren = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 64'(96 + k); mem_rlast = (k == 7);
      #1;
      chk($sformatf("miss3_rdata[%0d]", k), rdata, 64'(96 + k));
      chk($sformatf("miss3_rlast[%0d]", k), rlast, (k == 7));
    end
    @(negedge clk); mem_rvalid = 1'b0; mem_rlast = 1'b0; #1;
    chk("miss3_err", err, 1'b0);
    chk("miss3_idle_rvalid", rvalid, 1'b0);

    // Wide instance: offset 0x3C -> start beat 15
    @(negedge clk);
    b_flag_wren = 1'b1; b_flag_wdata = 1'b1; b_hd_wren = 1'b1;
    b_hd_wdata = mk_line2(32'hD00, 6'h3C);
    @(negedge clk); b_flag_wren = 1'b0; b_hd_wren = 1'b0; b_rready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); #1;
      chk($sformatf("wide_rvalid[%0d]", k), b_rvalid, 1'b1);
      chk($sformatf("wide_rdata[%0d]", k), b_rdata, 32'(12'hD00 + ((15 + k) % 16)));
      chk($sformatf("wide_rlast[%0d]", k), b_rlast, (k == 15));
    end
    @(negedge clk); #1;
    chk("wide_idle_rvalid", b_rvalid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
